// File: rtl/bcd_convert_sequencer_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter: FSM encoding,
// digit width and the sizing helper for the internal BCD accumulator.
package bcd_convert_sequencer_pkg;

    localparam int DIGIT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    // Each decimal digit covers a little over 3 binary bits, so ceil(bin_w/3)
    // digits always hold the largest input value without overflow.
    function automatic int int_digits(input int bin_w);
        return (bin_w + 2) / 3;
    endfunction

endpackage

// File: rtl/bcd_convert_sequencer_adj3.sv
// Double-dabble correction cell: a BCD digit of 5 or more gets +3 before the
// shift so that it carries correctly into the next digit.
module bcd_digit_adj3
    import bcd_convert_sequencer_pkg::*;
(
    input  logic [DIGIT_W-1:0] digit_i,
    output logic [DIGIT_W-1:0] digit_o
);

    assign digit_o = (digit_i >= 4'd5) ? digit_i + 4'd3 : digit_i;

endmodule

// File: rtl/bcd_convert_sequencer.sv
// Sequential binary-to-BCD converter, one input bit per clock (shift-and-add-3),
// with valid/ready handshakes on both sides and one conversion in flight.
module bcd_convert_sequencer
    import bcd_convert_sequencer_pkg::*;
#(
    parameter int BIN_W  = 20,
    parameter int DIGITS = 5
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [BIN_W-1:0]        binary_in,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DIGIT_W*DIGITS-1:0] bcd_out,
    output logic                    ovf,
    output logic                    busy
);

    localparam int INT_DIGITS = int_digits(BIN_W);
    localparam int ACC_W      = DIGIT_W * INT_DIGITS;
    localparam int OUT_W      = DIGIT_W * DIGITS;
    localparam int CNT_W      = $clog2(BIN_W);

    state_e             state_q, state_d;
    logic [BIN_W-1:0]   shift_q, shift_d;
    logic [ACC_W-1:0]   acc_q,   acc_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic [OUT_W-1:0]   bcd_q,   bcd_d;
    logic               ovf_q,   ovf_d;

    logic [ACC_W-1:0]       acc_adj;
    logic [ACC_W+BIN_W-1:0] cat_shifted;
    logic [ACC_W-1:0]       acc_shifted;
    logic [BIN_W-1:0]       bin_shifted;
    logic                   ovf_next;

    for (genvar g = 0; g < INT_DIGITS; g++) begin : g_adj
        bcd_digit_adj3 u_adj (
            .digit_i (acc_q[g*DIGIT_W +: DIGIT_W]),
            .digit_o (acc_adj[g*DIGIT_W +: DIGIT_W])
        );
    end

    assign cat_shifted = {acc_adj, shift_q} << 1;
    assign acc_shifted = cat_shifted[ACC_W+BIN_W-1:BIN_W];
    assign bin_shifted = cat_shifted[BIN_W-1:0];

    // Digits above the presented ones only feed the overflow flag.
    if (INT_DIGITS > DIGITS) begin : g_ovf
        assign ovf_next = |acc_shifted[ACC_W-1:OUT_W];
    end else begin : g_no_ovf
        assign ovf_next = 1'b0;
    end

    always_comb begin
        // NOTE: every next-state signal gets its hold value first, so no path leaves one unassigned and no latch is inferred.
        state_d = state_q;
        shift_d = shift_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        bcd_d   = bcd_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    shift_d = binary_in;
                    acc_d   = '0;
                    cnt_d   = CNT_W'(BIN_W - 1);
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                acc_d   = acc_shifted;
                shift_d = bin_shifted;
                if (cnt_q == '0) begin
                    bcd_d   = OUT_W'(acc_shifted);
                    ovf_d   = ovf_next;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            shift_q <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            bcd_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            bcd_q   <= bcd_d;
            ovf_q   <= ovf_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign busy      = (state_q == ST_SHIFT);
    assign bcd_out   = bcd_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_bcd_convert_sequencer.sv
// Self-checking bench for bcd_convert_sequencer: directed corner values plus
// random values, checked against a decimal-arithmetic reference model.
module tb_bcd_convert_sequencer;

    localparam int BIN_W  = 20;
    localparam int DIGITS = 5;
    localparam int LAT    = BIN_W + 1;

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  in_valid;
    logic                  in_ready;
    logic [BIN_W-1:0]      binary_in;
    logic                  out_valid;
    logic                  out_ready;
    logic [4*DIGITS-1:0]   bcd_out;
    logic                  ovf;
    logic                  busy;

    int checks = 0;
    int errors = 0;

    bcd_convert_sequencer #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .binary_in (binary_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .bcd_out   (bcd_out),
        .ovf       (ovf),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [4*DIGITS-1:0] ref_bcd(input int unsigned v);
        logic [4*DIGITS-1:0] r;
        int unsigned t;
        t = v;
        for (int i = 0; i < DIGITS; i++) begin
            r[i*4 +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    function automatic logic ref_ovf(input int unsigned v);
        return v >= 100000;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Starts from IDLE, one time unit after an edge; leaves the DUT back in IDLE.
    task automatic run_conv(input int unsigned value, input int hold);
        int edges;
        logic [4*DIGITS-1:0] exp_bcd;
        logic                exp_ovf;
        exp_bcd = ref_bcd(value);
        exp_ovf = ref_ovf(value);
        check("accept_ready", 32'(in_ready), 32'd1);
        in_valid  = 1'b1;
        binary_in = BIN_W'(value);
        tick();
        edges = 1;
        in_valid = 1'b0;
        check("busy_after_accept", 32'(busy), 32'd1);
        while (out_valid !== 1'b1 && edges < LAT + 20) begin
            binary_in = BIN_W'($urandom);
            out_ready = 1'($urandom);
            in_valid  = (edges == 5);
            tick();
            edges++;
        end
        in_valid = 1'b0;
        check("latency", 32'(edges), 32'(LAT));
        check("bcd_out", 32'(bcd_out), 32'(exp_bcd));
        check("ovf", 32'(ovf), 32'(exp_ovf));
        check("busy_done", 32'(busy), 32'd0);
        if (hold > 0) begin
            out_ready = 1'b0;
            in_valid  = 1'b1;
            binary_in = BIN_W'(7);
            for (int i = 0; i < hold; i++) begin
                tick();
                check("hold_valid", 32'(out_valid), 32'd1);
                check("hold_in_ready", 32'(in_ready), 32'd0);
                check("hold_bcd", 32'(bcd_out), 32'(exp_bcd));
                check("hold_ovf", 32'(ovf), 32'(exp_ovf));
            end
        end
        out_ready = 1'b1;
        tick();
        check("post_hs_valid", 32'(out_valid), 32'd0);
        check("post_hs_in_ready", 32'(in_ready), 32'd1);
        check("post_hs_busy", 32'(busy), 32'd0);
        in_valid  = 1'b0;
        out_ready = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        binary_in = '0;
        out_ready = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        tick();

        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_bcd", 32'(bcd_out), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);

        run_conv(0, 0);
        run_conv(12345, 0);
        run_conv(99999, 0);
        run_conv(100000, 0);
        run_conv(1048575, 10);

        // Reset at SHIFT cycle 8 discards the in-flight conversion.
        in_valid  = 1'b1;
        binary_in = BIN_W'(54321);
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        check("pre_rst_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        #1;
        check("async_rst_in_ready", 32'(in_ready), 32'd1);
        tick();
        reset = 1'b0;
        check("mid_rst_in_ready", 32'(in_ready), 32'd1);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_bcd", 32'(bcd_out), 32'd0);
        check("mid_rst_ovf", 32'(ovf), 32'd0);
        begin
            int seen;
            seen = 0;
            for (int i = 0; i < LAT + 10; i++) begin
                tick();
                if (out_valid !== 1'b0) seen++;
            end
            check("no_valid_after_rst", 32'(seen), 32'd0);
        end
        run_conv(54321, 0);

        for (int i = 0; i < 6; i++) begin
            run_conv(i[0] ? $urandom_range(0, 99999) : ($urandom & 32'hFFFFF), i % 3);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
